multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: opcode  input  6  instruction[31:26], valid from DECODE onward.
REQ-004 SHALL have port: funct  input  6  instruction[5:0].
REQ-005 SHALL have port: zero  input  1  ALU zero flag.
REQ-006 SHALL have ports, each output 1 bit: pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op.
REQ-007 SHALL have ports, each output 2 bits: alu_src_b (00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2) and pc_source (00 ALU result, 01 ALU-out register, 10 jump target).
REQ-008 SHALL have port: alu_op  output  3  ALU code (010 add, 110 sub, 000 and, 001 or, 111 slt).
REQ-009 SHALL have port: state  output  4  current state, for debug.

Function
REQ-010 SHALL be a Moore FSM, one state register, one transition per rising clk; the only Mealy terms are pc_en in BRANCH (gated by zero) and DECODE decoding of opcode/funct.
REQ-011 SHALL use states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11; codes 12-15 SHALL go to FETCH.
REQ-012 SHALL drive every output not listed for a state to 0, with alu_op defaulting to 010.
REQ-013 FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=010, pc_source=00, pc_en=1; next DECODE.
REQ-014 DECODE: alu_src_b=11, alu_op=010; next by opcode: 000000 EXECUTE, 100011/101011 MEM_ADDR, 000100 BRANCH, 001000 ADDI_EX.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010; next MEM_READ for 100011, MEM_WRITE for 101011.
REQ-016 MEM_READ: mem_read=1, iord=1; next MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-017 MEM_WRITE: mem_write=1, iord=1; next FETCH.
REQ-018 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; next R_WB.
REQ-019 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_source=01, pc_en=zero; next FETCH.
REQ-021 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=010; next ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-022 Any unsupported opcode, or opcode 000000 with an unsupported funct, in DECODE SHALL assert illegal_op for that one cycle and go to FETCH, with no reg_write/mem_write issued.
REQ-023 Latency in cycles including FETCH SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-024 mem_write and reg_write SHALL never be high in the same cycle; each SHALL be high for exactly one cycle per instruction.

Reset
REQ-025 While reset=1, state SHALL be FETCH, all 1-bit outputs and alu_src_b/pc_source SHALL be 0, and alu_op SHALL be 010, independent of clk.
REQ-026 The first rising clk after reset deassertion SHALL execute FETCH, so pc_en=1 and ir_write=1 in the cycle after release.
REQ-027 Reset asserted mid-instruction SHALL abort it immediately with no further writes; no state is retained.

Configuration
REQ-028 With macro MULTICYCLE_JUMP_EN defined, opcode 000010 in DECODE SHALL go to JUMP: pc_source=10, pc_en=1; next FETCH.
REQ-029 Without MULTICYCLE_JUMP_EN, opcode 000010 SHALL be treated as illegal per REQ-022, and state 9 SHALL be unreachable.

Verification
REQ-030 Reset pulse mid-EXECUTE -> outputs all zero with alu_op=010 immediately; FETCH (pc_en=1, ir_write=1) in the first cycle after release.
REQ-031 lw (opcode 100011) -> state sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4.
REQ-032 R-type sub (funct 100010) -> alu_op=110 in EXECUTE; reg_write=1 with reg_dst=1 in R_WB; total 4 cycles.
REQ-033 beq with zero=1 -> pc_en=1 with pc_source=01 in BRANCH; repeated with zero=0 -> pc_en=0; both return to FETCH.
REQ-034 opcode 111111, or R-type funct 000000 -> illegal_op=1 for one cycle in DECODE, then FETCH, with no reg_write or mem_write.
REQ-035 opcode 000010 -> with MULTICYCLE_JUMP_EN: state 9, pc_source=10, pc_en=1; without it: illegal_op=1.

Source files
------------

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Control FSM for a multicycle MIPS-subset datapath. Moore outputs derived
//   from the current state. There are two exceptions. pc_en in BRANCH follows the
//   ALU zero flag. illegal_op in DECODE follows the opcode and funct fields.
//
//   Optional feature: define MULTICYCLE_JUMP_EN to support the j instruction
//   (opcode 000010, state JUMP). When it is undefined, j is decoded as illegal.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   opcode[5:0] in   instruction[31:26], valid from DECODE onward
//   funct[5:0]  in   instruction[5:0]
//   zero        in   ALU zero flag
//   pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
//   reg_write, alu_src_a, illegal_op             out  1-bit datapath controls
//   alu_src_b[1:0]  out  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   pc_source[1:0]  out  00 ALU result, 01 ALU-out register, 10 jump target
//   alu_op[2:0]     out  010 add, 110 sub, 000 and, 001 or, 111 slt
//   state[3:0]      out  current state, for debug
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       illegal_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EX   = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       funct_ok;
  logic [2:0] funct_alu_op;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // R-type function decode, shared by DECODE (legality) and EXECUTE (ALU code).
  always_comb begin
    funct_ok     = 1'b1;
    funct_alu_op = ALU_ADD;
    case (funct)
      6'b100000: funct_alu_op = ALU_ADD;
      6'b100010: funct_alu_op = ALU_SUB;
      6'b100100: funct_alu_op = ALU_AND;
      6'b100101: funct_alu_op = ALU_OR;
      6'b101010: funct_alu_op = ALU_SLT;
      default:   funct_ok     = 1'b0;
    endcase
  end

  // NOTE: every output and state_d gets a default before the case so that no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = S_FETCH;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    illegal_op = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    alu_op     = ALU_ADD;

    // Reset forces the idle output pattern combinationally, so outputs are
    // quiet while reset is held even before any clock edge.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = 2'b01;
          pc_en     = 1'b1;
          state_d   = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE: begin
              if (funct_ok) state_d    = S_EXECUTE;
              else          illegal_op = 1'b1;
            end
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MULTICYCLE_JUMP_EN
            OP_J:         state_d = S_JUMP;
`else
            OP_J:         illegal_op = 1'b1;
`endif
            default:      illegal_op = 1'b1;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          state_d  = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = funct_alu_op;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_source = 2'b01;
          pc_en     = zero;
        end
`ifdef MULTICYCLE_JUMP_EN
        S_JUMP: begin
          pc_source = 2'b10;
          pc_en     = 1'b1;
        end
`else
        // Unreachable without the jump feature; idle outputs, back to FETCH.
        S_JUMP: state_d = S_FETCH;
`endif
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_ADDI_WB;
        end
        S_ADDI_WB: reg_write = 1'b1;
        default:   state_d   = S_FETCH;
      endcase
    end
  end

endmodule
